// File: rtl/game_background_fetch.sv
// Background fetch: turns VGA pixel coordinates into a 4-bit palette index via a
// 2x-upscaled, horizontally scrolled read of a synchronous background ROM.
module game_background_fetch #(
  parameter int         IMG_W       = 320,
  parameter int         IMG_H       = 240,
  parameter int         SCALE_SHIFT = 1,
  parameter int         ADDR_W      = 17,
  parameter logic [3:0] BLANK_INDEX = 4'h8
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              hs,
  input  logic              vs,
  input  logic [8:0]        scroll_x_in,
  input  logic              scroll_we,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              blank_out,
  output logic              hs_out,
  output logic              vs_out
);

  logic [9:0]        sx, sy;
  logic [10:0]       tsum, tx;
  logic [ADDR_W-1:0] addr_next;
  logic              in_image, scroll_legal, vs_fall;
  logic [8:0]        scroll_active, scroll_pending;
  logic              vs_q;
  logic              v1, v2;
  logic              blank1, blank2, hs1, hs2, vs1, vs2;

  // Both addends are below IMG_W whenever the pixel is inside the image, so one
  // conditional subtract is enough to wrap the scrolled column.
  always_comb begin
    sx           = DrawX >> SCALE_SHIFT;
    sy           = DrawY >> SCALE_SHIFT;
    tsum         = {1'b0, sx} + {2'b00, scroll_active};
    tx           = (32'(tsum) >= IMG_W) ? tsum - 11'(IMG_W) : tsum;
    addr_next    = ADDR_W'(32'(sy) * 32'(IMG_W) + 32'(tx));
    in_image     = blank && (32'(sx) < IMG_W) && (32'(sy) < IMG_H);
    scroll_legal = scroll_we && (32'(scroll_x_in) < IMG_W);
    vs_fall      = vs_q && !vs;
  end

  // Scroll only takes effect at the start of vsync, so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      scroll_pending <= '0;
      scroll_active  <= '0;
      vs_q           <= 1'b1;
    end else begin
      vs_q <= vs;
      if (scroll_legal)
        scroll_pending <= scroll_x_in;
      if (vs_fall)
        scroll_active <= scroll_legal ? scroll_x_in : scroll_pending;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      index     <= BLANK_INDEX;
      blank1    <= 1'b0;
      blank2    <= 1'b0;
      blank_out <= 1'b0;
      hs1       <= 1'b1;
      hs2       <= 1'b1;
      hs_out    <= 1'b1;
      vs1       <= 1'b1;
      vs2       <= 1'b1;
      vs_out    <= 1'b1;
    end else begin
      rom_addr  <= addr_next;
      v1        <= in_image;
      v2        <= v1;
      index     <= v2 ? rom_q : BLANK_INDEX;
      blank1    <= blank;
      blank2    <= blank1;
      blank_out <= blank2;
      hs1       <= hs;
      hs2       <= hs1;
      hs_out    <= hs2;
      vs1       <= vs;
      vs2       <= vs1;
      vs_out    <= vs2;
    end
  end

endmodule

// File: tb/tb_game_background_fetch.sv
// Randomized bench for game_background_fetch against a frame-level reference model
// (coordinate arithmetic, modulo wrap, frame-latched scroll) and a bench-side ROM.
module tb_game_background_fetch;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;

  logic        vga_clk = 1'b0;
  logic        reset, blank, hs, vs, scroll_we;
  logic [9:0]  DrawX, DrawY;
  logic [8:0]  scroll_x_in;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q, index;
  logic        blank_out, hs_out, vs_out;

  logic [3:0]  rom [0:131071];

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          chk;
    bit          achk;
    logic [16:0] addr;
    logic [3:0]  idx;
    logic        b;
    logic        h;
    logic        v;
  } rec_t;

  rec_t s1, s2, s3, rstrec;
  int   model_active, model_pending;
  bit   model_vs_prev;

  game_background_fetch dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .scroll_x_in(scroll_x_in),
    .scroll_we  (scroll_we),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index      (index),
    .blank_out  (blank_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom[rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pixel clock: drive inputs, predict the result, then compare what has
  // emerged from the pipeline half a cycle after the edge.
  task automatic applyStimulus(input bit r, input int x, input int y, input bit b,
                               input bit h, input bit v, input bit we, input int sval);
    rec_t rec;
    int   sx, sy, a;
    bit   legal;
    reset       = r;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    blank       = b;
    hs          = h;
    vs          = v;
    scroll_we   = we;
    scroll_x_in = 9'(sval);

    sx = x / 2;
    sy = y / 2;
    rec = '{chk: 1'b1, achk: 1'b0, addr: 17'd0, idx: 4'h8, b: b, h: h, v: v};
    if (b && sx < IMG_W && sy < IMG_H) begin
      a        = sy * IMG_W + (sx + model_active) % IMG_W;
      rec.achk = 1'b1;
      rec.addr = 17'(a);
      rec.idx  = rom[a];
    end
    if (r) rec = rstrec;

    if (r) begin
      model_active  = 0;
      model_pending = 0;
      model_vs_prev = 1'b1;
    end else begin
      legal = we && (sval < IMG_W);
      if (model_vs_prev && !v) model_active = legal ? sval : model_pending;
      if (legal) model_pending = sval;
      model_vs_prev = v;
    end

    @(posedge vga_clk);
    if (r) begin
      s1 = rec; s2 = rec; s3 = rec;
    end else begin
      s3 = s2; s2 = s1; s1 = rec;
    end
    @(negedge vga_clk);
    if (s3.chk) begin
      checkOutput("index", 32'(index), 32'(s3.idx));
      checkOutput("blank_out", 32'(blank_out), 32'(s3.b));
      checkOutput("hs_out", 32'(hs_out), 32'(s3.h));
      checkOutput("vs_out", 32'(vs_out), 32'(s3.v));
    end
    if (s1.achk) checkOutput("rom_addr", 32'(rom_addr), 32'(s1.addr));
  endtask

  task automatic sweepRow(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++)
      applyStimulus(1'b0, x, y, !(x >= 100 && x < 110), !(x >= 400 && x < 450), 1'b1, 1'b0, 0);
  endtask

  task automatic vsPulse();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 500, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 0, 500, 1'b0, 1'b1, 1'b1, 1'b0, 0);
  endtask

  initial begin
    s1 = '{default: '0};
    s2 = '{default: '0};
    s3 = '{default: '0};
    rstrec = '{chk: 1'b1, achk: 1'b1, addr: 17'd0, idx: 4'h8, b: 1'b0, h: 1'b1, v: 1'b1};
    model_active  = 0;
    model_pending = 0;
    model_vs_prev = 1'b1;
    for (int i = 0; i < 131072; i++) rom[i] = 4'($urandom);
    rom[0] = 4'h3;

    // Reset then release onto the top-left pixel
    applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("rst_release", 32'(index), 32'h3);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    // Full row sweep with a blanked and an hsync window
    sweepRow(2, 0, 639);

    // Scroll write mid-frame must not move addresses before vsync
    sweepRow(10, 0, 99);
    applyStimulus(1'b0, 100, 10, 1'b1, 1'b1, 1'b1, 1'b1, 300);
    sweepRow(10, 101, 299);
    applyStimulus(1'b0, 300, 10, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("scroll_pending_only", 32'(rom_addr), 32'd1750);
    sweepRow(10, 301, 639);
    vsPulse();
    applyStimulus(1'b0, 50, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("scroll_wrap", 32'(rom_addr), 32'd5);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("scroll_origin", 32'(rom_addr), 32'd300);
    sweepRow(0, 0, 639);

    // Illegal write is dropped; a legal write on the vsync edge applies at once
    applyStimulus(1'b0, 10, 40, 1'b1, 1'b1, 1'b1, 1'b1, 320);
    vsPulse();
    applyStimulus(1'b0, 50, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("illegal_kept", 32'(rom_addr), 32'd5);
    applyStimulus(1'b0, 0, 500, 1'b0, 1'b1, 1'b0, 1'b1, 7);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("edge_write", 32'(rom_addr), 32'd7);
    sweepRow(0, 1, 639);
    sweepRow(479, 600, 639);
    sweepRow(480, 0, 20);

    // Reset in the middle of a line
    sweepRow(4, 0, 199);
    applyStimulus(1'b1, 200, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("midrst_index", 32'(index), 32'h8);
    checkOutput("midrst_vs", 32'(vs_out), 32'h1);
    applyStimulus(1'b0, 201, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("midrst_scroll", 32'(rom_addr), 32'd740);
    sweepRow(4, 202, 639);

    // Randomized traffic, including out-of-range coordinates and illegal scrolls
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 300) == 0,
                    int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 520)),
                    ($urandom % 8) != 0,
                    ($urandom % 4) != 0,
                    ($urandom % 16) != 0,
                    ($urandom % 10) == 0,
                    int'($urandom_range(0, 511)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/game_background_fetch.md
Name: game_background_fetch

Overview:
- Upstream feeder for the game background palette lookup: converts the VGA controller's pixel coordinates into a 4-bit palette index.
- Reads a synchronous 4-bit-per-pixel background ROM at 2x upscale, with frame-latched horizontal scroll and wrap-around.
- Delays blank/hsync/vsync so they arrive aligned with the index.
- The index output drives the palette's index input directly.

Parameters:
- IMG_W, 320, source image width in pixels.
- IMG_H, 240, source image height in pixels.
- SCALE_SHIFT, 1, log2 of the upscale factor (screen pixel >> SCALE_SHIFT = source pixel).
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- BLANK_INDEX, 4'h8, index emitted outside the image or while blanked (palette black).

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row.
- blank  in  1  high = visible region, low = blanking.
- hs  in  1  hsync, active-low.
- vs  in  1  vsync, active-low.
- scroll_x_in  in  9  requested horizontal scroll, in source pixels.
- scroll_we  in  1  one-cycle write strobe for scroll_x_in.
- rom_addr  out  ADDR_W  address to the synchronous background ROM (1-cycle read latency).
- rom_q  in  4  ROM data, valid one cycle after rom_addr.
- index  out  4  palette index for the palette stage.
- blank_out  out  1  blank delayed to align with index.
- hs_out  out  1  hs delayed to align with index.
- vs_out  out  1  vs delayed to align with index.

Behaviour:
- Reset values: rom_addr=0, index=BLANK_INDEX, blank_out=0, hs_out=1, vs_out=1, scroll_active=0, scroll_pending=0, pipeline valid bits=0.
- Stage 1, registered at edge E1:
  - sx = DrawX>>SCALE_SHIFT; sy = DrawY>>SCALE_SHIFT.
  - tx = sx + scroll_active; if tx >= IMG_W then tx -= IMG_W. A single subtract suffices because both operands are < IMG_W.
  - rom_addr = sy*IMG_W + tx, computed at full width then truncated to ADDR_W.
  - v1 = blank && sx < IMG_W && sy < IMG_H.
  - When v1=0, rom_addr still updates; its value is don't-care.
- Stage 2, at edge E2: v2 = v1. rom_q becomes valid after this edge.
- Stage 3, at edge E3: index = v2 ? rom_q : BLANK_INDEX.
- Latency: DrawX/DrawY sampled at E0 produce index at E3 (3 cycles). blank, hs and vs pass through an identical 3-stage delay, so all four outputs stay aligned.
- Scroll write:
  - On scroll_we with scroll_x_in < IMG_W, scroll_pending <= scroll_x_in.
  - Writes with scroll_x_in >= IMG_W are dropped and scroll_pending is unchanged.
  - Multiple writes within a frame: last write wins.
- Scroll apply:
  - vs_q holds vs registered one cycle.
  - On a vsync falling edge (vs_q=1, vs=0), scroll_active <= scroll_pending.
  - If scroll_we is asserted on the edge cycle with a legal value, scroll_active takes scroll_x_in directly in that cycle.
  - scroll_active never changes except on this edge, so there is no tearing mid-frame.
- Boundaries:
  - DrawX=639 with SCALE_SHIFT=1 gives sx=319, the last column.
  - DrawX >= 640 or DrawY >= 480 (sx/sy out of range) gives BLANK_INDEX.
  - Wrap example: scroll 300, sx=25 gives tx=5.
  - Reset asserted mid-frame returns all state to reset values on the next edge. The first valid index appears 3 cycles after reset is released, provided the input is visible.
- No backpressure: one index is produced per clock, unconditionally.

Test Plan:
- Reset held 2 cycles, then released with blank=1, DrawX=0, DrawY=0, ROM[0]=4'h3 -> index=8, hs_out=1, vs_out=1 during reset; index=3 exactly 3 cycles after the inputs are applied.
- Sweep DrawX 0..639 on row DrawY=2, with the ROM programmed so that ROM[a] = a[3:0] -> rom_addr = 320 + (DrawX>>1); index follows with 3-cycle latency; each source pixel is repeated twice.
- Toggle blank low at DrawX=100 -> index=8 for exactly the blanked cycles, shifted by 3; blank_out, hs_out and vs_out match the inputs delayed by 3.
- Write scroll_x_in=300 mid-frame -> addresses are unchanged until the vs falling edge. After the edge, DrawX=50 (sx=25) on row 0 gives rom_addr=5, and DrawX=0 gives rom_addr=300.
- Write scroll_x_in=320 (illegal), then a vs falling edge -> scroll_active keeps its previous value. A legal write of 7 on the same cycle as the vs edge -> scroll_active=7 immediately.
- Assert reset mid-line at DrawX=200 -> next edge: index=8, vs_out=1, scroll_active=0; normal output resumes 3 cycles after release.
